// File: rtl/shift_ram_stream.sv
// Activation buffer: bounds-checked random-access writes, windowed valid/ready read stream.
// Optional power-on zero fill of the whole memory when SHIFT_RAM_CLEAR_EN is defined.
module shift_ram_stream #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 156800,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              rd_wrap,
  input  logic              rd_abort,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_done,
  output logic              busy
);

  localparam int                MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
`ifdef SHIFT_RAM_CLEAR_EN
  localparam logic [1:0] S_CLEAR  = 2'd2;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] base, len_m1, addr, beat;
  logic              wrap, fetch_done;
  logic              inflight, inflight_last;
  logic [DATA_W-1:0] rdq;
  logic [1:0]        occ;
  logic [1:0][DATA_W-1:0] sk_data;
  logic [1:0]        sk_last;
  logic              wr_err_q, done_q;
`ifdef SHIFT_RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  logic              in_stream, pop, fetch, pass_end, wr_ok;
  logic [1:0]        pend;
  logic [ADDR_W-1:0] addr_inc, base_eff, len_sel;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    in_stream = (state == S_STREAM);
    pop       = (occ != 2'd0) && rd_ready;
    // Slots still claimed after this cycle's pop; keeps 1 beat/clk with a 2-entry buffer.
    pend      = occ - {1'b0, pop} + {1'b0, inflight};
    fetch     = in_stream && !rd_abort && !fetch_done && (pend < 2'd2);
    pass_end  = (beat == len_m1);
    addr_inc  = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    base_eff  = ({1'b0, rd_base} >= DEPTH_X) ? ADDR_W'({1'b0, rd_base} - DEPTH_X) : rd_base;
    len_sel   = (rd_len == '0) ? LAST_ADDR : rd_len - 1'b1;
    wr_ok     = wr_en && ({1'b0, wr_addr} < DEPTH_X);
    mem_we    = rst && wr_ok;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
`ifdef SHIFT_RAM_CLEAR_EN
    if (state == S_CLEAR) begin
      wr_ok     = 1'b0;
      mem_we    = rst;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
`endif
  end

  // Read-before-write falls out of the non-blocking read of the old word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr[MEM_AW-1:0]] <= mem_wdata;
    if (fetch)  rdq <= mem[addr[MEM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef SHIFT_RAM_CLEAR_EN
      state    <= S_CLEAR;
      clr_addr <= '0;
`else
      state    <= S_IDLE;
`endif
      base          <= '0;
      len_m1        <= '0;
      addr          <= '0;
      beat          <= '0;
      wrap          <= 1'b0;
      fetch_done    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= 2'd0;
      sk_data       <= '0;
      sk_last       <= '0;
      wr_err_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      wr_err_q <= wr_en && !wr_ok;
      done_q   <= 1'b0;

      case (state)
        S_IDLE: if (rd_start) begin
          state      <= S_STREAM;
          base       <= base_eff;
          addr       <= base_eff;
          len_m1     <= len_sel;
          wrap       <= rd_wrap;
          beat       <= '0;
          fetch_done <= 1'b0;
        end
        S_STREAM: begin
          if (rd_abort) state <= S_IDLE;
          else if (pop && sk_last[0] && !wrap) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
`ifdef SHIFT_RAM_CLEAR_EN
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase

      if (fetch) begin
        if (pass_end) begin
          beat <= '0;
          addr <= base;
          if (!wrap) fetch_done <= 1'b1;
        end else begin
          beat <= beat + 1'b1;
          addr <= addr_inc;
        end
      end
      inflight      <= fetch;
      inflight_last <= fetch && pass_end;

      if (in_stream && rd_abort) occ <= 2'd0;
      else begin
        case ({pop, inflight})
          2'b01: begin
            if (occ == 2'd0) begin
              sk_data[0] <= rdq;
              sk_last[0] <= inflight_last;
            end else begin
              sk_data[1] <= rdq;
              sk_last[1] <= inflight_last;
            end
            occ <= occ + 2'd1;
          end
          2'b10: begin
            sk_data[0] <= sk_data[1];
            sk_last[0] <= sk_last[1];
            occ        <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              sk_data[0] <= rdq;
              sk_last[0] <= inflight_last;
            end else begin
              sk_data[0] <= sk_data[1];
              sk_last[0] <= sk_last[1];
              sk_data[1] <= rdq;
              sk_last[1] <= inflight_last;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_valid = (occ != 2'd0);
  assign rd_data  = sk_data[0];
  assign rd_last  = rd_valid && sk_last[0];
  assign wr_err   = wr_err_q;
  assign rd_done  = done_q;
  assign busy     = (state != S_IDLE);

endmodule
